// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results to MEM/WB and runs req/ready data-memory accesses for loads/stores.
// Optional MISALIGN_TRAP_EN adds misalign_o/misalign_addr_o and traps misaligned halfword/word ops.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [31:0]       store_data_i,
  input  logic [2:0]        funct3_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              reg_write_i,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid_o,
  output logic [31:0]       wb_data_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic              wb_reg_write_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic        mem_op, misalign, mem_go, done, accept;
  logic [1:0]  off;
  logic [31:0] wdata_n, alu32, load_data;
  logic [3:0]  wstrb_n;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Offset is forced to the natural alignment of the access size; with the
  // trap enabled a misaligned op never reaches the memory, so this is harmless.
  always_comb begin
    mem_op = in_valid & (mem_read_i | mem_write_i);
    case (funct3_i[1:0])
      2'b01:   off = {alu_result_i[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = alu_result_i[1:0];
    endcase
`ifdef MISALIGN_TRAP_EN
    misalign = mem_op & (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                         ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0])));
`else
    misalign = 1'b0;
`endif
    mem_go  = mem_op & ~misalign;
    done    = (state == BUSY) & dmem_ready;
    stall_o = mem_go & ~done;
    accept  = in_valid & ~stall_o;
    alu32   = 32'(alu_result_i);
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wdata_n = {4{store_data_i[7:0]}};
        wstrb_n = 4'b0001 << off;
      end
      2'b01: begin
        wdata_n = {2{store_data_i[15:0]}};
        wstrb_n = 4'b0011 << off;
      end
      default: begin
        wdata_n = store_data_i;
        wstrb_n = 4'b1111;
      end
    endcase
  end

  always_comb begin
    lane8  = dmem_rdata[{off_q, 3'b000} +: 8];
    lane16 = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{lane8[7]}}, lane8};
      3'b100:  load_data = {24'b0, lane8};
      3'b001:  load_data = {{16{lane16[15]}}, lane16};
      3'b101:  load_data = {16'b0, lane16};
      default: load_data = dmem_rdata;
    endcase
  end

  assign dmem_req = (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      case (state)
        IDLE: if (mem_go) begin
          state      <= BUSY;
          dmem_we    <= mem_write_i;
          dmem_addr  <= {alu_result_i[ADDR_W-1:2], 2'b00};
          dmem_wdata <= wdata_n;
          dmem_wstrb <= mem_write_i ? wstrb_n : 4'b0000;
          f3_q       <= funct3_i;
          off_q      <= off;
        end
        BUSY: if (dmem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_o      <= 1'b0;
      wb_data_o       <= '0;
      wb_rd_o         <= '0;
      wb_reg_write_o  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      if (accept) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= rd_i;
        if (misalign) begin
          wb_reg_write_o  <= 1'b0;
          wb_data_o       <= '0;
`ifdef MISALIGN_TRAP_EN
          misalign_o      <= 1'b1;
          misalign_addr_o <= alu_result_i;
`endif
        end else begin
          wb_reg_write_o <= reg_write_i;
          wb_data_o      <= mem_read_i ? load_data : (mem_write_i ? 32'h0 : alu32);
        end
      end else begin
        wb_valid_o     <= 1'b0;
        wb_reg_write_o <= 1'b0;
      end
    end
  end

endmodule
